instr_decode: RTL and testbench
===============================

# instr_decode

Decode stage of the five-stage ARMv8 (LEGv8 subset) pipeline, directly downstream of instruction fetch. Holds the IF/ID pipeline register, the 32×64-bit architectural register file, the main control decoder and the immediate sign-extender. Consumes the fetched instruction and PC, and produces operands, the extended immediate and control signals for the ID/EX latch. Accepts writeback from the WB stage.

## Interface
- `DATA_W`, default `` `WORD `` (64): register, PC and immediate width.
- `INSTR_W`, default `` `INSTR_LEN `` (32): instruction width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `if_instruction` in INSTR_W: instruction from fetch.
- `if_pc` in DATA_W: PC of `if_instruction`.
- `stall` in 1: hold the IF/ID register.
- `flush` in 1: load a bubble into IF/ID.
- `wb_reg_write` in 1: writeback enable.
- `wb_rd` in 5: writeback register index.
- `wb_data` in DATA_W: writeback data.
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_pc` out DATA_W: latched PC.
- `read_data1` out DATA_W: Rn operand.
- `read_data2` out DATA_W: Rm, or Rt when `reg2loc`=1.
- `sign_ext_imm` out DATA_W: extended immediate.
- `write_reg` out 5: destination index, instr[4:0].
- `reg2loc`, `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `branch`, `uncond_branch` out 1 each: control signals.
- `alu_op` out 2: 00 add, 01 pass-B/zero-test, 10 R-type funct.
- `illegal` out 1: valid instruction with an unrecognised opcode.

## Operation
- **IF/ID register** (`id_instr`, `id_pc`, `id_valid`):
  - Priority at each posedge: flush, then stall, then load.
  - flush: instr←0, valid←0.
  - stall: hold.
  - otherwise: instr←`if_instruction`, pc←`if_pc`, valid←1.
- **Register file**: 32×DATA_W.
  - Write at posedge when `wb_reg_write`=1 and `wb_rd`≠31.
  - Reads are combinational from `id_instr`. Index 31 (XZR) always reads 0.
  - Read addr1 = instr[9:5].
  - Read addr2 = `reg2loc` ? instr[4:0] : instr[20:16].
- **Decode**, on opcode instr[31:21]:
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: reg_write, alu_op=10.
  - ADDI 1001000100x: reg_write, alu_src, alu_op=10.
  - LDUR 11111000010: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - STUR 11111000000: reg2loc, alu_src, mem_write, alu_op=00.
  - CBZ 10110100xxx: reg2loc, branch, alu_op=01.
  - B 000101xxxxx: uncond_branch.
  - Anything else: all controls 0, `illegal`=1.
- **Bubble gating**: when `id_valid`=0, all controls, `illegal` and `sign_ext_imm` are 0.
- **Immediate formation**:
  - D-type: sext(instr[20:12]).
  - ADDI: zext(instr[21:10]).
  - CBZ: sext(instr[23:5]).
  - B: sext(instr[25:0]).
  - R-type: 0.
  - Branch offsets are in words, unshifted; the branch adder applies <<2.

## Timing
- Reset: IF/ID instr=0, pc=0, valid=0; all 32 registers 0; every output 0.
- Fetch-to-outputs latency is 1 cycle. Outputs settle combinationally after the edge that loads IF/ID.
- Writeback data is readable at the next cycle with `WB_BYPASS_EN` off, and in the same cycle with it on.
- stall and flush together: flush wins.
- Write to X31: dropped; reads stay 0.
- Reset asserted mid-stall or mid-write: reset wins; the write is lost.

## Configuration
- `INSTR_DECODE_WB_BYPASS_EN` defined: if `wb_reg_write`=1 and `wb_rd` matches a read address (≠31), that read port returns `wb_data` in the same cycle (write-first).
- Not defined: a read during a same-index write returns the old value. The pipeline then relies on a stall for WB→ID hazards.

## Structure
- Shared package / `definitions.vh`:
  - Opcode constants (`OP_ADD`, `OP_SUB`, `OP_AND`, `OP_ORR`, `OP_ADDI`, `OP_LDUR`, `OP_STUR`, `OP_CBZ`, `OP_B`).
  - `ALU_OP_*` codes.
  - `XZR`=5'd31.
- One sub-module: `reg_file` (32×DATA_W, two read ports, one write port, XZR handling, bypass under the macro). IF/ID latch, decoder and extender stay in `instr_decode`.

## Test plan
- Reset, then release with no stall: load 0x8B020020 (ADD X0,X1,X2), X1=5, X2=7 → next cycle read_data1=5, read_data2=7, reg_write=1, alu_op=10, write_reg=0.
- LDUR X3,[X4,#-8] (0xF85F8083) → sign_ext_imm=0xFFFFFFFFFFFFFFF8, mem_read=1, mem_to_reg=1, alu_src=1.
- CBZ X5,#-2 (0xB4FFFFC5) → reg2loc=1, branch=1, read_data2=X5, imm=-2. B #4 (0x14000004) → uncond_branch=1, imm=4.
- stall high for 3 cycles while `if_instruction` changes → IF/ID unchanged. stall and flush together → id_valid=0, all controls 0.
- wb write X31=0xDEAD → X31 still reads 0. Write X6=0x1234 while decoding a read of X6 → 0x1234 same cycle with the macro, old value without.
- Opcode 0xFFFFFFFF → illegal=1, controls 0. Assert reset mid-run → all outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared LEGv8 decode constants: opcode patterns, ALU op codes, XZR index and the control bundle.
package instr_decode_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    localparam logic [4:0] XZR = 5'd31;

    // Full 11-bit opcodes; shorter ones are compared against the top bits of instr[31:21].
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_PASSB = 2'b01,
        ALU_OP_RTYPE = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_D,
        IMM_I,
        IMM_CB,
        IMM_B
    } imm_sel_e;

    typedef struct packed {
        logic    reg2loc;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    uncond_branch;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/instr_decode_reg_file.sv
// 32-entry register file, 2 combinational read ports, 1 write port; X31 reads 0 and ignores writes.
// INSTR_DECODE_WB_BYPASS_EN: a same-cycle write to a read index is forwarded (write-first).
module instr_decode_reg_file
    import instr_decode_pkg::*;
#(
    parameter int DATA_W = WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [4:0]        wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [4:0]        ra1_i,
    input  logic [4:0]        ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    logic [DATA_W-1:0] regs_q [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != XZR)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = (ra1_i == XZR) ? '0 : regs_q[ra1_i];
`ifdef INSTR_DECODE_WB_BYPASS_EN
        if (we_i && (ra1_i != XZR) && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
`endif
    end

    always_comb begin
        rd2_o = (ra2_i == XZR) ? '0 : regs_q[ra2_i];
`ifdef INSTR_DECODE_WB_BYPASS_EN
        if (we_i && (ra2_i != XZR) && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
`endif
    end

endmodule

// File: rtl/instr_decode.sv
// LEGv8 decode stage: IF/ID register (flush > stall > load), register file, control decode, immediate extend.
// Outputs valid 1 cycle after fetch; stall holds IF/ID. WB forwarding under INSTR_DECODE_WB_BYPASS_EN.
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int DATA_W  = WORD,
    parameter int INSTR_W = INSTR_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] if_instruction,
    input  logic [DATA_W-1:0]  if_pc,
    input  logic               stall,
    input  logic               flush,
    input  logic               wb_reg_write,
    input  logic [4:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               id_valid,
    output logic [DATA_W-1:0]  id_pc,
    output logic [DATA_W-1:0]  read_data1,
    output logic [DATA_W-1:0]  read_data2,
    output logic [DATA_W-1:0]  sign_ext_imm,
    output logic [4:0]         write_reg,
    output logic               reg2loc,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               branch,
    output logic               uncond_branch,
    output logic [1:0]         alu_op,
    output logic               illegal
);

    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [DATA_W-1:0]  id_pc_q, id_pc_d;
    logic               id_valid_q, id_valid_d;

    always_comb begin
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_instr_d = '0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_instr_d = if_instruction;
            id_pc_d    = if_pc;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr_q <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else begin
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    logic [10:0] opc;
    ctrl_t       dec_ctrl, ctrl;
    imm_sel_e    imm_sel;
    logic        dec_illegal;

    assign opc = id_instr_q[31:21];

    always_comb begin
        dec_ctrl    = '0;
        imm_sel     = IMM_NONE;
        dec_illegal = 1'b0;
        if ((opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_ORR)) begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = ALU_OP_RTYPE;
        end else if (opc[10:1] == OP_ADDI) begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.alu_op    = ALU_OP_RTYPE;
            imm_sel            = IMM_I;
        end else if (opc == OP_LDUR) begin
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.alu_op     = ALU_OP_ADD;
            imm_sel             = IMM_D;
        end else if (opc == OP_STUR) begin
            dec_ctrl.reg2loc   = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_op    = ALU_OP_ADD;
            imm_sel            = IMM_D;
        end else if (opc[10:3] == OP_CBZ) begin
            dec_ctrl.reg2loc = 1'b1;
            dec_ctrl.branch  = 1'b1;
            dec_ctrl.alu_op  = ALU_OP_PASSB;
            imm_sel          = IMM_CB;
        end else if (opc[10:5] == OP_B) begin
            dec_ctrl.uncond_branch = 1'b1;
            imm_sel                = IMM_B;
        end else begin
            dec_illegal = 1'b1;
        end
    end

    // A bubble must look like a NOP downstream, whatever bits sit in IF/ID.
    assign ctrl    = id_valid_q ? dec_ctrl : '0;
    assign illegal = id_valid_q & dec_illegal;

    always_comb begin
        sign_ext_imm = '0;
        unique case (imm_sel)
            IMM_D:   sign_ext_imm = {{(DATA_W-9){id_instr_q[20]}}, id_instr_q[20:12]};
            IMM_I:   sign_ext_imm = {{(DATA_W-12){1'b0}}, id_instr_q[21:10]};
            IMM_CB:  sign_ext_imm = {{(DATA_W-19){id_instr_q[23]}}, id_instr_q[23:5]};
            IMM_B:   sign_ext_imm = {{(DATA_W-26){id_instr_q[25]}}, id_instr_q[25:0]};
            default: sign_ext_imm = '0;
        endcase
        if (!id_valid_q) begin
            sign_ext_imm = '0;
        end
    end

    logic [4:0] ra2;
    assign ra2 = ctrl.reg2loc ? id_instr_q[4:0] : id_instr_q[20:16];

    instr_decode_reg_file #(
        .DATA_W (DATA_W)
    ) u_reg_file (
        .clk   (clk),
        .reset (reset),
        .we_i  (wb_reg_write),
        .wa_i  (wb_rd),
        .wd_i  (wb_data),
        .ra1_i (id_instr_q[9:5]),
        .ra2_i (ra2),
        .rd1_o (read_data1),
        .rd2_o (read_data2)
    );

    assign id_valid      = id_valid_q;
    assign id_pc         = id_pc_q;
    assign write_reg     = id_instr_q[4:0];
    assign reg2loc       = ctrl.reg2loc;
    assign alu_src       = ctrl.alu_src;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign branch        = ctrl.branch;
    assign uncond_branch = ctrl.uncond_branch;
    assign alu_op        = ctrl.alu_op;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: directed stimulus queues expected outputs per cycle, a negedge monitor compares.
module tb_instr_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        stall, flush, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        id_valid;
    logic [63:0] id_pc, read_data1, read_data2, sign_ext_imm;
    logic [4:0]  write_reg;
    logic        reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond_branch;
    logic [1:0]  alu_op;
    logic        illegal;

    instr_decode dut (
        .clk            (clk),
        .reset          (reset),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .stall          (stall),
        .flush          (flush),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .sign_ext_imm   (sign_ext_imm),
        .write_reg      (write_reg),
        .reg2loc        (reg2loc),
        .alu_src        (alu_src),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .branch         (branch),
        .uncond_branch  (uncond_branch),
        .alu_op         (alu_op),
        .illegal        (illegal)
    );

    // Control vector: reg2loc alu_src mem_to_reg reg_write mem_read mem_write branch uncond alu_op[1:0] illegal
    localparam logic [10:0] C_NONE = 11'b00000000000;
    localparam logic [10:0] C_R    = 11'b00010000100;
    localparam logic [10:0] C_ADDI = 11'b01010000100;
    localparam logic [10:0] C_LD   = 11'b01111000000;
    localparam logic [10:0] C_ST   = 11'b11000100000;
    localparam logic [10:0] C_CBZ  = 11'b10000010010;
    localparam logic [10:0] C_B    = 11'b00000001000;
    localparam logic [10:0] C_ILL  = 11'b00000000001;

    localparam logic [31:0] I_ADD    = 32'h8B020020; // ADD X0,X1,X2
    localparam logic [31:0] I_LDUR   = 32'hF85F8083; // LDUR X3,[X4,#-8]
    localparam logic [31:0] I_CBZ    = 32'hB4FFFFC5; // CBZ X5,#-2
    localparam logic [31:0] I_B      = 32'h14000004; // B #4
    localparam logic [31:0] I_ADDI   = 32'h913FFC27; // ADDI X7,X1,#0xFFF
    localparam logic [31:0] I_STUR   = 32'hF8010022; // STUR X2,[X1,#16]
    localparam logic [31:0] I_XZR    = 32'h8B1F03E0; // ADD X0,XZR,XZR
    localparam logic [31:0] I_ADD_X6 = 32'h8B0600C0; // ADD X0,X6,X6
    localparam logic [31:0] I_ADD_X9 = 32'h8B090120; // ADD X0,X9,X9

`ifdef INSTR_DECODE_WB_BYPASS_EN
    localparam logic [63:0] BP_SAME = 64'h1234;
`else
    localparam logic [63:0] BP_SAME = 64'h1111;
`endif

    typedef struct {
        int          cyc;
        string       nm;
        logic        vld;
        logic [63:0] pc;
        logic [10:0] ctrl;
        logic [63:0] imm;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [4:0]  wreg;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] act_ctrl;
    assign act_ctrl = {reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                       branch, uncond_branch, alu_op, illegal};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: stale entry for cycle %0d, now %0d", e.nm, e.cyc, cyc);
                end else begin
                    chk({e.nm, ".valid"}, {63'd0, id_valid}, {63'd0, e.vld});
                    chk({e.nm, ".pc"},    id_pc,             e.pc);
                    chk({e.nm, ".ctrl"},  {53'd0, act_ctrl}, {53'd0, e.ctrl});
                    chk({e.nm, ".imm"},   sign_ext_imm,      e.imm);
                    chk({e.nm, ".rd1"},   read_data1,        e.rd1);
                    chk({e.nm, ".rd2"},   read_data2,        e.rd2);
                    chk({e.nm, ".wreg"},  {59'd0, write_reg}, {59'd0, e.wreg});
                end
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic st,
                         input logic fl, input logic we, input logic [4:0] rd, input logic [63:0] wd);
        @(posedge clk);
        #1;
        if_instruction = ins;
        if_pc          = pc;
        stall          = st;
        flush          = fl;
        wb_reg_write   = we;
        wb_rd          = rd;
        wb_data        = wd;
    endtask

    task automatic expect_at(input int c, input string nm, input logic v, input logic [63:0] pc,
                             input logic [10:0] ctrl, input logic [63:0] imm, input logic [63:0] rd1,
                             input logic [63:0] rd2, input logic [4:0] wr);
        exp_t e;
        e.cyc  = c;
        e.nm   = nm;
        e.vld  = v;
        e.pc   = pc;
        e.ctrl = ctrl;
        e.imm  = imm;
        e.rd1  = rd1;
        e.rd2  = rd2;
        e.wreg = wr;
        sb.push_back(e);
    endtask

    initial begin : stimulus
        reset          = 1'b1;
        if_instruction = '0;
        if_pc          = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        wb_reg_write   = 1'b0;
        wb_rd          = '0;
        wb_data        = '0;

        drive(32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc, "reset", 1'b0, 64'h0, C_NONE, 64'h0, 64'h0, 64'h0, 5'd0);

        // Fill registers while IF/ID is flushed.
        drive(32'h0, 64'h0, 1'b0, 1'b1, 1'b1, 5'd1, 64'd5);
        reset = 1'b0;
        expect_at(cyc + 1, "flush_bubble", 1'b0, 64'h0, C_NONE, 64'h0, 64'h0, 64'h0, 5'd0);
        drive(32'h0, 64'h0, 1'b0, 1'b1, 1'b1, 5'd2,  64'd7);
        drive(32'h0, 64'h0, 1'b0, 1'b1, 1'b1, 5'd4,  64'h100);
        drive(32'h0, 64'h0, 1'b0, 1'b1, 1'b1, 5'd5,  64'h55);
        drive(32'h0, 64'h0, 1'b0, 1'b1, 1'b1, 5'd6,  64'h1111);
        drive(32'h0, 64'h0, 1'b0, 1'b1, 1'b1, 5'd31, 64'hDEAD);

        drive(I_ADD,  64'h100, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "add",  1'b1, 64'h100, C_R,    64'h0, 64'd5, 64'd7, 5'd0);
        drive(I_LDUR, 64'h104, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "ldur", 1'b1, 64'h104, C_LD,   64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 64'h0, 5'd3);
        drive(I_CBZ,  64'h108, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "cbz",  1'b1, 64'h108, C_CBZ,  64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h55, 5'd5);
        drive(I_B,    64'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "b",    1'b1, 64'h10C, C_B,    64'd4, 64'h0, 64'h0, 5'd4);
        drive(I_ADDI, 64'h110, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "addi", 1'b1, 64'h110, C_ADDI, 64'hFFF, 64'd5, 64'h0, 5'd7);
        drive(I_STUR, 64'h114, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "stur", 1'b1, 64'h114, C_ST,   64'd16, 64'd5, 64'd7, 5'd2);
        drive(32'hFFFF_FFFF, 64'h118, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "illegal", 1'b1, 64'h118, C_ILL, 64'h0, 64'h0, 64'h0, 5'd31);
        drive(I_XZR,  64'h11C, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "xzr_read", 1'b1, 64'h11C, C_R, 64'h0, 64'h0, 64'h0, 5'd0);

        drive(I_ADD,  64'h120, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "pre_stall", 1'b1, 64'h120, C_R, 64'h0, 64'd5, 64'd7, 5'd0);
        for (int i = 0; i < 3; i++) begin
            drive(I_LDUR ^ i, 64'h200 + 64'(i), 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
            expect_at(cyc + 1, "stall_hold", 1'b1, 64'h120, C_R, 64'h0, 64'd5, 64'd7, 5'd0);
        end
        drive(I_LDUR, 64'h300, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "stall_flush", 1'b0, 64'h120, C_NONE, 64'h0, 64'h0, 64'h0, 5'd0);

        drive(I_ADD_X6, 64'h400, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "bp_pre", 1'b1, 64'h400, C_R, 64'h0, 64'h1111, 64'h1111, 5'd0);
        drive(I_ADD_X6, 64'h404, 1'b1, 1'b0, 1'b1, 5'd6, 64'h1234);
        expect_at(cyc, "bp_same", 1'b1, 64'h400, C_R, 64'h0, BP_SAME, BP_SAME, 5'd0);
        drive(I_ADD_X6, 64'h408, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc, "bp_after", 1'b1, 64'h400, C_R, 64'h0, 64'h1234, 64'h1234, 5'd0);

        // Reset mid-stall with a write pending: must clear everything before the next edge.
        drive(I_ADD, 64'h500, 1'b1, 1'b0, 1'b1, 5'd9, 64'h99);
        reset = 1'b1;
        expect_at(cyc, "async_reset", 1'b0, 64'h0, C_NONE, 64'h0, 64'h0, 64'h0, 5'd0);
        drive(I_ADD, 64'h504, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        reset = 1'b0;
        expect_at(cyc + 1, "post_reset", 1'b1, 64'h504, C_R, 64'h0, 64'h0, 64'h0, 5'd0);
        drive(I_ADD_X9, 64'h508, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        expect_at(cyc + 1, "reset_drops_wb", 1'b1, 64'h508, C_R, 64'h0, 64'h0, 64'h0, 5'd0);

        drive(32'h0, 64'h0, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
